mem_access_sequencer: RTL and testbench

MEM-stage controller for the LC-3b pipeline. It turns the single-cycle `mem_read` / `mem_write` intent from the control word into a sequenced data-memory transaction. That covers direct word and byte accesses, plus the two-access indirect LDI/STI sequence. It holds the pipeline stalled until the final memory response, then presents load data to writeback for exactly one cycle.

---
 rtl/mem_access_sequencer.sv | 152 +++++++++++++++
 tb/tb_mem_access_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: LC-3b MEM-stage sequencer for word, byte and indirect (LDI/STI) data accesses.
// Define MEM_SEQ_PERF_EN to build the stall-cycle and completed-access counters.
module mem_access_sequencer #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid_in,
    input  logic [3:0]        opcode,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [ADDR_W-1:0] dmem_address,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [1:0]        dmem_byte_enable,
    input  logic              dmem_resp,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] rdata_out,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_accesses
);
    localparam logic [3:0] OP_LDB = 4'h2;
    localparam logic [3:0] OP_STB = 4'h3;
    localparam logic [3:0] OP_LDI = 4'hA;
    localparam logic [3:0] OP_STI = 4'hB;

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;

    state_t            state_q, state_d;
    logic              ind_q, ind_d, byte_q, byte_d, wr_q, wr_d, hi_q, hi_d;
    logic [ADDR_W-2:0] addr_q, addr_d, ptr_q, ptr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic              req;

    assign req       = valid_in & (mem_read | mem_write);
    assign done      = state_q == DONE;
    assign rdata_out = rdata_q;

    always_comb begin
        state_d          = state_q;
        ind_d            = ind_q;
        byte_d           = byte_q;
        wr_d             = wr_q;
        hi_d             = hi_q;
        addr_d           = addr_q;
        ptr_d            = ptr_q;
        wdata_d          = wdata_q;
        rdata_d          = rdata_q;
        stall            = 1'b0;
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_address     = '0;
        dmem_wdata       = '0;
        dmem_byte_enable = 2'b00;
        case (state_q)
            IDLE: if (req) begin
                stall   = 1'b1;
                state_d = ACC1;
                ind_d   = (opcode == OP_LDI) | (opcode == OP_STI);
                byte_d  = (opcode == OP_LDB) | (opcode == OP_STB);
                // only STI ever writes on an indirect; a read+write control word resolves to a read
                wr_d    = (opcode == OP_STI) | ((opcode != OP_LDI) & mem_write & ~mem_read);
                addr_d  = addr_in[ADDR_W-1:1];
                hi_d    = addr_in[0];
                wdata_d = wdata_in;
            end
            ACC1: begin
                stall            = 1'b1;
                dmem_read        = ind_q | ~wr_q;
                dmem_write       = ~ind_q & wr_q;
                dmem_address     = {addr_q, 1'b0};
                dmem_wdata       = (~ind_q & wr_q) ? (byte_q ? {wdata_q[7:0], wdata_q[7:0]} : wdata_q) : '0;
                dmem_byte_enable = byte_q ? (hi_q ? 2'b10 : 2'b01) : 2'b11;
                if (dmem_resp) begin
                    state_d = ind_q ? ACC2 : DONE;
                    ptr_d   = ind_q ? dmem_rdata[ADDR_W-1:1] : ptr_q;
                    if (~ind_q & ~wr_q)
                        rdata_d = byte_q ? {{(DATA_W-8){1'b0}}, hi_q ? dmem_rdata[15:8] : dmem_rdata[7:0]}
                                         : dmem_rdata;
                end
            end
            ACC2: begin
                stall            = 1'b1;
                dmem_read        = ~wr_q;
                dmem_write       = wr_q;
                dmem_address     = {ptr_q, 1'b0};
                dmem_wdata       = wr_q ? wdata_q : '0;
                dmem_byte_enable = 2'b11;
                if (dmem_resp) begin
                    state_d = DONE;
                    rdata_d = wr_q ? rdata_q : dmem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ind_q   <= 1'b0;
            byte_q  <= 1'b0;
            wr_q    <= 1'b0;
            hi_q    <= 1'b0;
            addr_q  <= '0;
            ptr_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ind_q   <= ind_d;
            byte_q  <= byte_d;
            wr_q    <= wr_d;
            hi_q    <= hi_d;
            addr_q  <= addr_d;
            ptr_q   <= ptr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef MEM_SEQ_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, acc_cnt_q, acc_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, stall};
        acc_cnt_d   = acc_cnt_q + {31'd0, done};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            acc_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            acc_cnt_q   <= acc_cnt_d;
        end
    end

    assign perf_stall_cycles = stall_cnt_q;
    assign perf_accesses     = acc_cnt_q;
`else
    assign perf_stall_cycles = '0;
    assign perf_accesses     = '0;
`endif
endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb_mem_access_sequencer: directed and randomized transactions against a sparse-memory reference model.
module tb_mem_access_sequencer;
    logic        clk = 1'b0;
    logic        reset_n, valid_in, mem_read, mem_write, dmem_resp;
    logic [3:0]  opcode;
    logic [15:0] addr_in, wdata_in, dmem_rdata;
    logic        dmem_read, dmem_write, stall, done;
    logic [15:0] dmem_address, dmem_wdata, rdata_out;
    logic [1:0]  dmem_byte_enable;
    logic [31:0] perf_stall_cycles, perf_accesses;

    always #5 clk = ~clk;

    mem_access_sequencer dut (
        .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .opcode(opcode),
        .mem_read(mem_read), .mem_write(mem_write), .addr_in(addr_in), .wdata_in(wdata_in),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
        .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable), .dmem_resp(dmem_resp),
        .dmem_rdata(dmem_rdata), .stall(stall), .done(done), .rdata_out(rdata_out),
        .perf_stall_cycles(perf_stall_cycles), .perf_accesses(perf_accesses)
    );

    logic [15:0] mem [logic [15:0]];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_stall = 0;
    logic [31:0] exp_acc = 0;
    logic [15:0] exp_rdata = 0;

    function automatic logic [15:0] mrd(input logic [15:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 16'h5A3C);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_perf();
`ifdef MEM_SEQ_PERF_EN
        chk("perf_stall", perf_stall_cycles, exp_stall);
        chk("perf_acc", perf_accesses, exp_acc);
`else
        chk("perf_stall", perf_stall_cycles, 0);
        chk("perf_acc", perf_accesses, 0);
`endif
    endtask

    // one memory access of `waits` wait cycles, entered and left at a negedge
    task automatic access(input logic [15:0] a, input logic we, input logic [1:0] be,
                          input logic [15:0] wd, input int waits, output logic [15:0] rd);
        logic [15:0] old;
        for (int k = 0; k <= waits; k++) begin
            chk("stall_acc", stall, 1);
            chk("done_acc", done, 0);
            chk("rd_strobe", dmem_read, !we);
            chk("wr_strobe", dmem_write, we);
            chk("addr", dmem_address, a);
            chk("be", dmem_byte_enable, be);
            if (we) chk("wdata", dmem_wdata, wd);
            valid_in   = 1'($urandom_range(0, 1));
            dmem_resp  = (k == waits);
            dmem_rdata = we ? 16'($urandom) : mrd(a);
            if (k == waits) begin
                old = mrd(a);
                rd  = old;
                if (we) mem[a] = {be[1] ? wd[15:8] : old[15:8], be[0] ? wd[7:0] : old[7:0]};
            end
            exp_stall++;
            @(posedge clk);
            @(negedge clk);
            dmem_resp = 1'b0;
        end
    endtask

    task automatic txn(input logic [3:0] op, input logic r, input logic w, input logic [15:0] a,
                       input logic [15:0] wd, input int w1, input int w2);
        logic ind, byt, st;
        logic [15:0] al, wd1, d;
        logic [1:0] be1;
        ind = (op == 4'hA) || (op == 4'hB);
        byt = (op == 4'h2) || (op == 4'h3);
        st  = (op == 4'hB) || (!ind && w && !r);
        al  = {a[15:1], 1'b0};
        be1 = byt ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
        wd1 = byt ? {wd[7:0], wd[7:0]} : wd;
        valid_in = 1'b1; opcode = op; mem_read = r; mem_write = w; addr_in = a; wdata_in = wd;
        #1;
        chk("stall_req", stall, 1);
        chk("strobe_req", {dmem_read, dmem_write}, 0);
        chk("done_req", done, 0);
        exp_stall++;
        @(posedge clk);
        @(negedge clk);
        if (ind) begin
            access(al, 1'b0, 2'b11, 16'h0, w1, d);
            access({d[15:1], 1'b0}, st, 2'b11, wd, w2, d);
            if (!st) exp_rdata = d;
        end else begin
            access(al, st, be1, wd1, w1, d);
            if (!st) exp_rdata = byt ? {8'h00, a[0] ? d[15:8] : d[7:0]} : d;
        end
        chk("done", done, 1);
        chk("stall_done", stall, 0);
        chk("strobe_done", {dmem_read, dmem_write}, 0);
        chk("rdata", rdata_out, exp_rdata);
        valid_in = 1'b0;
        exp_acc++;
        @(posedge clk);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("rdata_hold", rdata_out, exp_rdata);
        check_perf();
    endtask

    task automatic idle_cycle();
        valid_in = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        #1;
        chk("stall_idle", stall, 0);
        chk("strobe_idle", {dmem_read, dmem_write}, 0);
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    initial begin
        logic [3:0] ops [7];
        logic [3:0] op;
        logic r, w;
        ops = '{4'h6, 4'h7, 4'hF, 4'h2, 4'h3, 4'hA, 4'hB};
        reset_n = 1'b0; valid_in = 1'b0; opcode = 4'h0; mem_read = 1'b0; mem_write = 1'b0;
        addr_in = 16'h0; wdata_in = 16'h0; dmem_resp = 1'b0; dmem_rdata = 16'h0;
        repeat (2) @(negedge clk);
        chk("rst_strobes", {dmem_read, dmem_write}, 0);
        chk("rst_addr", dmem_address, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_be", dmem_byte_enable, 0);
        chk("rst_stall_done", {stall, done}, 0);
        chk("rst_rdata", rdata_out, 0);
        check_perf();
        reset_n = 1'b1;
        @(negedge clk);

        mem[16'h3004] = 16'hBEEF;
        txn(4'h6, 1'b1, 1'b0, 16'h3005, 16'h0, 2, 0);
        txn(4'h3, 1'b0, 1'b1, 16'h4001, 16'h12A5, 0, 0);
        mem[16'h4000] = 16'h7F80;
        txn(4'h2, 1'b1, 1'b0, 16'h4000, 16'h0, 0, 0);
        mem[16'h2000] = 16'h3001;
        mem[16'h3000] = 16'h5555;
        txn(4'hA, 1'b1, 1'b0, 16'h2000, 16'h0, 0, 0);
        mem[16'h2000] = 16'h6000;
        txn(4'hB, 1'b0, 1'b1, 16'h2000, 16'h1234, 0, 1);
        txn(4'h7, 1'b1, 1'b1, 16'h3005, 16'hDEAD, 1, 0);

        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(0, 6)];
            r  = (op == 4'h7 || op == 4'h3 || op == 4'hB) ? ($urandom_range(0, 3) == 0) : 1'b1;
            w  = (op == 4'h7 || op == 4'h3 || op == 4'hB) ? 1'b1 : 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) idle_cycle();
            txn(op, r, w, 16'h1000 | 16'($urandom_range(0, 63)), 16'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3));
        end

        mem[16'h2000] = 16'h6000;
        valid_in = 1'b1; opcode = 4'hB; mem_read = 1'b0; mem_write = 1'b1;
        addr_in = 16'h2000; wdata_in = 16'h1234;
        @(posedge clk);
        @(negedge clk);
        chk("sti_rst_acc1", {dmem_read, dmem_write}, 2'b10);
        dmem_resp = 1'b1; dmem_rdata = 16'h6000;
        @(posedge clk);
        @(negedge clk);
        dmem_resp = 1'b0;
        chk("sti_rst_acc2_wr", {dmem_read, dmem_write}, 2'b01);
        chk("sti_rst_acc2_addr", dmem_address, 16'h6000);
        reset_n = 1'b0;
        valid_in = 1'b0;
        #1;
        chk("rst_mid_strobes", {dmem_read, dmem_write}, 0);
        chk("rst_mid_stall_done", {stall, done}, 0);
        exp_stall = 0; exp_acc = 0; exp_rdata = 0;
        check_perf();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_done", done, 0);
        chk("post_rst_strobes", {dmem_read, dmem_write}, 0);
        chk("post_rst_rdata", rdata_out, 0);
        txn(4'h6, 1'b1, 1'b0, 16'h3005, 16'h0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
